// File: rtl/for_loop_ctrl_if.sv
// Handshake bundle between a counted-loop controller and its surroundings:
// start/trip-count request, per-iteration body launch/completion, and loop status.
interface for_loop_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             go;
    logic [IDX_W-1:0] bound;
    logic             body_go;
    logic [IDX_W-1:0] body_idx;
    logic             body_done;
    logic             busy;
    logic             done;

    modport master (
        output go, bound, body_done,
        input  body_go, body_idx, busy, done
    );

    modport slave (
        input  go, bound, body_done,
        output body_go, body_idx, busy, done
    );
endinterface

// File: rtl/for_loop_ctrl.sv
// Counted-loop controller: launches a single-iteration body once per index
// 0..bound-1, waiting for the body's done pulse between launches.
module for_loop_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    for_loop_ctrl_if.slave lp
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] bound_r;
    logic [IDX_W-1:0] bound_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= IDX_ZERO;
            bound_r <= IDX_ZERO;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            bound_r <= bound_nxt;
        end
    end

    // go and body_done are only looked at in the one state that expects them,
    // so stray pulses elsewhere are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        bound_nxt = bound_r;
        unique case (state)
            IDLE: begin
                if (lp.go) begin
                    bound_nxt = lp.bound;
                    idx_nxt   = IDX_ZERO;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (idx < bound_r) state_nxt = ISSUE;
                else               state_nxt = FINISH;
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // idx never passes bound_r, so this increment cannot wrap.
                if (lp.body_done) begin
                    idx_nxt   = idx + IDX_ONE;
                    state_nxt = CHECK;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign lp.body_idx = idx;
    assign lp.busy     = (state != IDLE);
    assign lp.body_go  = (state == ISSUE);
    assign lp.done     = (state == FINISH);
endmodule

// File: tb/tb_for_loop_ctrl.sv
// Scoreboard bench for for_loop_ctrl: directed loops push expected body_go/done
// events; a negedge monitor pops and compares whenever the DUT pulses one.
module tb_for_loop_ctrl;
    localparam int IDX_W = 4;

    typedef struct {
        bit             is_done;
        logic [IDX_W-1:0] idx;
        int             cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cnt = 0;
    int   base = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   resp_lat = 1;
    bit   issue_glitch = 1'b0;
    ev_t  expq[$];

    for_loop_ctrl_if #(.IDX_W(IDX_W)) lp();

    for_loop_ctrl #(.IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .lp    (lp.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    initial begin
        lp.go = 1'b0;
        lp.bound = '0;
        lp.body_done = 1'b0;
    end

    // Body model: answers each body_go with a done pulse resp_lat cycles later;
    // optionally also raises body_done during the ISSUE cycle itself.
    always begin
        @(negedge clk);
        if (lp.body_go) begin
            if (issue_glitch) lp.body_done = 1'b1;
            @(posedge clk); #1;
            lp.body_done = (resp_lat == 1);
            for (int i = 2; i <= resp_lat; i++) begin
                @(posedge clk); #1;
                lp.body_done = (i == resp_lat);
            end
            @(posedge clk); #1;
            lp.body_done = 1'b0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (lp.body_go || lp.done) begin
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got body_go=%0b done=%0b idx=%0d cycle=%0d, required no event",
                         lp.body_go, lp.done, lp.body_idx, cnt - base);
            end else begin
                ev_t e;
                e = expq.pop_front();
                if (lp.body_go && lp.done) begin
                    n_err++;
                    $display("FAIL event_overlap: got body_go=1 done=1, required exactly one");
                end else if (lp.done != e.is_done || cnt != e.cyc ||
                             (!e.is_done && lp.body_idx != e.idx)) begin
                    n_err++;
                    $display("FAIL event: got done=%0b idx=%0d cycle=%0d, required done=%0b idx=%0d cycle=%0d",
                             lp.done, lp.body_idx, cnt - base, e.is_done, e.idx, e.cyc - base);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic at_cycle(int rel);
        while (cnt < base + rel) begin
            @(posedge clk); #1;
        end
    endtask

    // Issues go for one cycle and queues n_push body_go events (plus done if asked)
    // assuming uniform body latency lat.
    task automatic start(int bnd, int lat, int n_push, bit push_done);
        ev_t e;
        @(posedge clk); #1;
        lp.go = 1'b1;
        lp.bound = IDX_W'(bnd);
        base = cnt;
        resp_lat = lat;
        for (int k = 0; k < n_push; k++) begin
            e.is_done = 1'b0;
            e.idx = IDX_W'(k);
            e.cyc = base + 2 + k * (2 + lat);
            expq.push_back(e);
        end
        if (push_done) begin
            e.is_done = 1'b1;
            e.idx = '0;
            e.cyc = base + 2 + bnd * (2 + lat);
            expq.push_back(e);
        end
        @(posedge clk); #1;
        lp.go = 1'b0;
    endtask

    task automatic drain(string name);
        int t = 0;
        while ((expq.size() != 0 || lp.busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        n_vec++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending events busy=%0b, required 0 pending and idle",
                     name, expq.size(), lp.busy);
            expq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", lp.busy, 0);
        chk("rst_done", lp.done, 0);
        chk("rst_body_go", lp.body_go, 0);
        chk("rst_body_idx", lp.body_idx, 0);

        // bound=3, L=1; also a go pulse during FINISH must not start a new loop
        start(3, 1, 3, 1);
        at_cycle(11);
        chk("b3_busy_c11", lp.busy, 1);
        lp.go = 1'b1;
        lp.bound = 4'd2;
        @(posedge clk); #1;
        lp.go = 1'b0;
        chk("b3_busy_c12", lp.busy, 0);
        drain("b3");

        // bound=0: no body_go, done in cycle 2
        start(0, 1, 0, 1);
        chk("b0_busy_c1", lp.busy, 1);
        at_cycle(2);
        chk("b0_busy_c2", lp.busy, 1);
        at_cycle(3);
        chk("b0_busy_c3", lp.busy, 0);
        drain("b0");

        // bound=2, L=4, go/bound change during WAIT, body_done during ISSUE
        issue_glitch = 1'b1;
        start(2, 4, 2, 1);
        at_cycle(4);
        lp.go = 1'b1;
        lp.bound = 4'd7;
        @(posedge clk); #1;
        lp.go = 1'b0;
        at_cycle(15);
        chk("b2_busy_c15", lp.busy, 0);
        drain("b2");
        issue_glitch = 1'b0;

        // bound=15, full index range without wrap
        start(15, 1, 15, 1);
        at_cycle(46);
        chk("b15_idx_c46", lp.body_idx, 15);
        drain("b15");

        // Reset during WAIT of iteration 1 aborts without done
        start(5, 1, 2, 0);
        at_cycle(6);
        chk("abort_wait_idx", lp.body_idx, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", lp.busy, 0);
        chk("abort_done", lp.done, 0);
        chk("abort_body_go", lp.body_go, 0);
        chk("abort_body_idx", lp.body_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        drain("abort");

        // bound=1 after abort, then a back-to-back loop started right after FINISH
        start(1, 1, 1, 1);
        at_cycle(5);
        chk("b1_done_c5", lp.done, 1);
        start(2, 1, 2, 1);
        drain("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
